inst_queue: RTL and testbench

Instruction queue between the instruction fetcher and the dispatcher.
- Buffers fetched instructions together with their pc, predicted-jump flag and roll-back pc in a circular FIFO.
- Presents the oldest entry to the dispatcher under a valid/ready handshake.
- Back-pressures the fetcher through a full signal that accounts for one push already in flight.
- Flushes completely on a ROB misbranch.

---
 rtl/inst_queue.sv | 141 ++++++++++++++
 tb/tb_inst_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
// Circular instruction queue that sits between the instruction fetcher and
// the dispatcher. Each entry holds the instruction, its pc, the predictor's
// taken flag and the roll-back pc. The oldest entry is offered to the
// dispatcher with a valid/ready handshake. A ROB misbranch empties the queue.
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active low
//   rdy                    global ready; low freezes all state
//   push_signal            fetcher push pulse; entry inputs valid this cycle
//   inst_in                fetched instruction
//   pc_in                  pc of the instruction
//   predicted_jump_in      branch predictor taken flag
//   roll_back_pc_in        pc used to recover on a mispredict
//   iq_full_signal         back-pressure to the fetcher
//   dsp_ready              dispatcher takes the head entry this cycle
//   out_valid              head entry is valid (queue not empty)
//   inst_to_dsp            head instruction
//   pc_to_dsp              head pc
//   predicted_jump_to_dsp  head predicted flag
//   roll_back_pc_to_dsp    head roll-back pc
//   misbranch_flag         flush request from the ROB
//   count_out              current occupancy, 0..DEPTH
//   overflow_err           sticky flag: a push arrived while completely full
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             push_signal,
    input  logic [31:0]      inst_in,
    input  logic [31:0]      pc_in,
    input  logic             predicted_jump_in,
    input  logic [31:0]      roll_back_pc_in,
    output logic             iq_full_signal,
    input  logic             dsp_ready,
    output logic             out_valid,
    output logic [31:0]      inst_to_dsp,
    output logic [31:0]      pc_to_dsp,
    output logic             predicted_jump_to_dsp,
    output logic [31:0]      roll_back_pc_to_dsp,
    input  logic             misbranch_flag,
    output logic [PTR_W:0]   count_out,
    output logic             overflow_err
);

    localparam logic [PTR_W:0] CountFull   = (PTR_W + 1)'(DEPTH);
    // The fetcher acts on a not-full sample one cycle late, so up to two
    // more pushes can still land after it last saw room.
    localparam logic [PTR_W:0] CountThresh = (PTR_W + 1)'(DEPTH - 2);

    logic [31:0] instMem [DEPTH];
    logic [31:0] pcMem   [DEPTH];
    logic        pjMem   [DEPTH];
    logic [31:0] rbMem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic pushReq;
    logic doPush;
    logic doPop;
    logic doFlush;

    assign out_valid      = (count_q != '0);
    assign iq_full_signal = (count_q >= CountThresh);
    assign count_out      = count_q;
    assign overflow_err   = overflow_q;

    assign inst_to_dsp           = out_valid ? instMem[head_q] : '0;
    assign pc_to_dsp             = out_valid ? pcMem[head_q]   : '0;
    assign predicted_jump_to_dsp = out_valid ? pjMem[head_q]   : 1'b0;
    assign roll_back_pc_to_dsp   = out_valid ? rbMem[head_q]   : '0;

    // The full test uses the pre-edge count, so a pop on the same edge does
    // not make room for a push that arrives while the queue is full.
    assign doFlush = rdy && misbranch_flag;
    assign pushReq = rdy && push_signal && !misbranch_flag;
    assign doPush  = pushReq && (count_q != CountFull);
    assign doPop   = rdy && out_valid && dsp_ready && !misbranch_flag;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (doFlush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                tail_d = tail_q + 1'b1;
            end
            if (doPop) begin
                head_d = head_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_d = count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_d = count_q - 1'b1;
            end
            if (pushReq && (count_q == CountFull)) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage carries no reset; only slots between head and tail are
    // ever observed, and those have always been written first.
    always_ff @(posedge clk) begin
        if (doPush) begin
            instMem[tail_q] <= inst_in;
            pcMem[tail_q]   <= pc_in;
            pjMem[tail_q]   <= predicted_jump_in;
            rbMem[tail_q]   <= roll_back_pc_in;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
// Directed self-checking bench for inst_queue. Each pushed entry derives its
// payload from its pc: inst = pc ^ 0x13, predicted flag = pc[2],
// roll-back pc = pc + 4.
// ---------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic             push_signal;
    logic [31:0]      inst_in;
    logic [31:0]      pc_in;
    logic             predicted_jump_in;
    logic [31:0]      roll_back_pc_in;
    logic             iq_full_signal;
    logic             dsp_ready;
    logic             out_valid;
    logic [31:0]      inst_to_dsp;
    logic [31:0]      pc_to_dsp;
    logic             predicted_jump_to_dsp;
    logic [31:0]      roll_back_pc_to_dsp;
    logic             misbranch_flag;
    logic [PTR_W:0]   count_out;
    logic             overflow_err;

    int assertCount = 0;
    int failCount   = 0;

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .push_signal           (push_signal),
        .inst_in               (inst_in),
        .pc_in                 (pc_in),
        .predicted_jump_in     (predicted_jump_in),
        .roll_back_pc_in       (roll_back_pc_in),
        .iq_full_signal        (iq_full_signal),
        .dsp_ready             (dsp_ready),
        .out_valid             (out_valid),
        .inst_to_dsp           (inst_to_dsp),
        .pc_to_dsp             (pc_to_dsp),
        .predicted_jump_to_dsp (predicted_jump_to_dsp),
        .roll_back_pc_to_dsp   (roll_back_pc_to_dsp),
        .misbranch_flag        (misbranch_flag),
        .count_out             (count_out),
        .overflow_err          (overflow_err)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check every head field against the payload derived from the pc
    task automatic checkHead(input string tag, input logic [31:0] pc);
        logic [31:0] rb;
        rb = pc + 32'd4;
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ".pc"}, 64'(pc_to_dsp), 64'(pc));
        checkOutput({tag, ".inst"}, 64'(inst_to_dsp), 64'(pc ^ 32'h13));
        checkOutput({tag, ".pj"}, 64'(predicted_jump_to_dsp), 64'(pc[2]));
        checkOutput({tag, ".rb"}, 64'(roll_back_pc_to_dsp), 64'(rb));
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus, then return the pulse inputs to idle
    task automatic applyStimulus(input logic pushEn, input logic [31:0] pc,
                                 input logic popEn, input logic misb,
                                 input logic rdyV);
        push_signal       = pushEn;
        pc_in             = pc;
        inst_in           = pc ^ 32'h13;
        predicted_jump_in = pc[2];
        roll_back_pc_in   = pc + 32'd4;
        dsp_ready         = popEn;
        misbranch_flag    = misb;
        rdy               = rdyV;
        step();
        push_signal    = 1'b0;
        dsp_ready      = 1'b0;
        misbranch_flag = 1'b0;
        rdy            = 1'b1;
    endtask

    initial begin
        logic [31:0] expQ[$];
        int modelCount;
        int pushed;
        int popped;
        int cycles;
        logic fullObs;
        logic fullPrev;

        rst = 1'b0;
        rdy = 1'b1;
        push_signal = 1'b0;
        inst_in = '0;
        pc_in = '0;
        predicted_jump_in = 1'b0;
        roll_back_pc_in = '0;
        dsp_ready = 1'b0;
        misbranch_flag = 1'b0;

        // ---- Reset state and single entry ----
        step();
        step();
        checkOutput("rst.count", 64'(count_out), 64'd0);
        checkOutput("rst.valid", 64'(out_valid), 64'd0);
        checkOutput("rst.full", 64'(iq_full_signal), 64'd0);
        checkOutput("rst.ovf", 64'(overflow_err), 64'd0);
        checkOutput("rst.inst", 64'(inst_to_dsp), 64'd0);
        checkOutput("rst.rb", 64'(roll_back_pc_to_dsp), 64'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("single.count", 64'(count_out), 64'd1);
        checkHead("single", 32'h0);
        checkOutput("single.inst13", 64'(inst_to_dsp), 64'h13);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("single.popValid", 64'(out_valid), 64'd0);
        checkOutput("single.popCount", 64'(count_out), 64'd0);
        checkOutput("single.popInst", 64'(inst_to_dsp), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("single.emptyPop", 64'(count_out), 64'd0);

        // ---- Fill with a fetcher that honours full one cycle late ----
        modelCount = 0;
        fullObs = 1'b0;
        fullPrev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic doPush;
            doPush = !fullPrev;
            applyStimulus(doPush, 32'(modelCount * 4), 1'b0, 1'b0, 1'b1);
            if (doPush) modelCount++;
            checkOutput("fill.count", 64'(count_out), 64'(modelCount));
            checkOutput("fill.full", 64'(iq_full_signal), 64'(modelCount >= DEPTH - 2));
            fullPrev = fullObs;
            fullObs = iq_full_signal;
        end
        checkOutput("fill.final", 64'(count_out), 64'd15);
        checkOutput("fill.ovf", 64'(overflow_err), 64'd0);
        for (int i = 0; i < 15; i++) begin
            checkHead("drain", 32'(i * 4));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("drain.valid", 64'(out_valid), 64'd0);

        // ---- Wrap-around: 40 entries, popping on alternate cycles ----
        pushed = 0;
        popped = 0;
        cycles = 0;
        while ((popped < 40) && (cycles < 400)) begin
            logic doPush;
            logic doPop;
            logic [31:0] pc;
            pc = 32'h2000 + 32'(pushed * 4);
            doPush = (pushed < 40) && !iq_full_signal;
            doPop = out_valid && ((cycles % 2 == 1) || (pushed == 40));
            if (doPop) begin
                checkHead("wrap", expQ.pop_front());
                popped++;
            end
            if (doPush) begin
                expQ.push_back(pc);
                pushed++;
            end
            applyStimulus(doPush, pc, doPop, 1'b0, 1'b1);
            cycles++;
        end
        checkOutput("wrap.popped", 64'(popped), 64'd40);
        checkOutput("wrap.count", 64'(count_out), 64'd0);

        // ---- Simultaneous push and pop at count 5 ----
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        end
        checkOutput("simul.pre", 64'(count_out), 64'd5);
        applyStimulus(1'b1, 32'h314, 1'b1, 1'b0, 1'b1);
        checkOutput("simul.count", 64'(count_out), 64'd5);
        for (int i = 0; i < 5; i++) begin
            checkHead("simul", 32'h304 + 32'(i * 4));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("simul.empty", 64'(out_valid), 64'd0);

        // ---- Misbranch flush with a same-edge push and pop ----
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        end
        checkOutput("flush.pre", 64'(count_out), 64'd7);
        applyStimulus(1'b1, 32'h600, 1'b1, 1'b1, 1'b1);
        checkOutput("flush.count", 64'(count_out), 64'd0);
        checkOutput("flush.valid", 64'(out_valid), 64'd0);
        checkOutput("flush.pc", 64'(pc_to_dsp), 64'd0);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        checkOutput("flush.after", 64'(count_out), 64'd1);
        checkHead("flush.head", 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // ---- Overflow: 17 pushes ignoring full ----
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        end
        checkOutput("ovf.count16", 64'(count_out), 64'd16);
        checkOutput("ovf.notYet", 64'(overflow_err), 64'd0);
        checkOutput("ovf.full", 64'(iq_full_signal), 64'd1);
        applyStimulus(1'b1, 32'h440, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf.count17", 64'(count_out), 64'd16);
        checkOutput("ovf.set", 64'(overflow_err), 64'd1);
        checkHead("ovf.head", 32'h400);
        // Pop while full with a push: push is still dropped
        applyStimulus(1'b1, 32'h444, 1'b1, 1'b0, 1'b1);
        checkOutput("ovf.popPush", 64'(count_out), 64'd15);
        checkOutput("ovf.sticky", 64'(overflow_err), 64'd1);
        checkHead("ovf.head2", 32'h404);

        // ---- rdy low freezes everything ----
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h700, 1'b1, 1'b1, 1'b0);
            checkOutput("rdy.count", 64'(count_out), 64'd15);
            checkOutput("rdy.ovf", 64'(overflow_err), 64'd1);
            checkHead("rdy.head", 32'h404);
        end
        for (int i = 0; i < 15; i++) begin
            checkHead("ovfDrain", 32'h404 + 32'(i * 4));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("ovfDrain.valid", 64'(out_valid), 64'd0);
        checkOutput("ovf.stillSet", 64'(overflow_err), 64'd1);

        // ---- Asynchronous reset mid-stream ----
        applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h804, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #2;
        checkOutput("arst.count", 64'(count_out), 64'd0);
        checkOutput("arst.valid", 64'(out_valid), 64'd0);
        checkOutput("arst.ovf", 64'(overflow_err), 64'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h900, 1'b0, 1'b0, 1'b1);
        checkOutput("arst.push", 64'(count_out), 64'd1);
        checkHead("arst.head", 32'h900);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
